// File: rtl/alu_pkg.sv
// Shared ALU encodings for the MIPS execute stage: ALU control codes, main-decoder
// ALUOp values and the R-type funct fields the control decoder understands.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_t;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct to 4-bit ALU control decoder; unsupported R-type funct
// values fall back to ADD and raise illegal so the op still flows downstream.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_OR:  alu_ctrl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default: begin
            alu_ctrl = ALU_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue/capture: S1 registers drive the external ALU, S2 captures its result.
// Optional completed-op counter enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [15:0]      op_count
);

  logic       s1_valid;
  logic       s1_illegal;
  logic       s2_free;
  logic       accept;
  logic       advance;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // Readiness looks only at stage occupancy and out_ready, never at in_valid.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= ALU_ADD;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_illegal <= dec_illegal;
      alu_a      <= rs_data;
      alu_b      <= alu_src ? imm : rt_data;
      alu_ctrl   <= dec_ctrl;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= alu_result;
        out_zero    <= alu_zero;
        out_illegal <= s1_illegal;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_valid && out_ready && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign op_count = count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a behavioural ALU closing the loop.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        alu_src;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_src     (alu_src),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .imm         (imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setOp(input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    alu_op  = op;
    funct   = fn;
    alu_src = src;
    rs_data = a;
    rt_data = b;
    imm     = im;
  endtask

  // Present one op at the negedge and hold it across exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic src,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    setOp(op, fn, src, a, b, im);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    setOp(2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    #2;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_alu_ctrl", alu_ctrl, 4'b0010);
    checkOutput("reset_alu_a", alu_a, 0);
    checkOutput("reset_out_result", out_result, 0);
    checkOutput("reset_op_count", op_count, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b10, 6'b100010, 1'b0, 32'd10, 32'd3, 32'd0);
    checkOutput("sub_alu_ctrl", alu_ctrl, 4'b0110);
    checkOutput("sub_alu_a", alu_a, 32'd10);
    checkOutput("sub_alu_b", alu_b, 32'd3);
    checkOutput("sub_out_valid_early", out_valid, 0);
    nextEdge();
    checkOutput("sub_out_valid", out_valid, 1);
    checkOutput("sub_out_result", out_result, 32'd7);
    checkOutput("sub_out_zero", out_zero, 0);
    checkOutput("sub_out_illegal", out_illegal, 0);

    applyStimulus(2'b01, 6'd0, 1'b0, 32'd5, 32'd5, 32'd0);
    checkOutput("beq_alu_ctrl", alu_ctrl, 4'b0110);
    nextEdge();
    checkOutput("beq_out_zero", out_zero, 1);
    checkOutput("beq_out_result", out_result, 0);

    applyStimulus(2'b00, 6'd0, 1'b1, 32'd100, 32'd7, 32'hFFFF_FFFC);
    checkOutput("addi_alu_ctrl", alu_ctrl, 4'b0010);
    checkOutput("addi_alu_b", alu_b, 32'hFFFF_FFFC);
    nextEdge();
    checkOutput("addi_out_result", out_result, 32'd96);

    applyStimulus(2'b10, 6'b101010, 1'b0, 32'd2, 32'd9, 32'd0);
    checkOutput("slt_alu_ctrl", alu_ctrl, 4'b0111);
    nextEdge();
    checkOutput("slt_out_result", out_result, 32'd1);

    applyStimulus(2'b10, 6'b100100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0);
    checkOutput("and_alu_ctrl", alu_ctrl, 4'b0000);
    nextEdge();
    checkOutput("and_out_result", out_result, 32'h0000_00F0);

    applyStimulus(2'b11, 6'd0, 1'b1, 32'h0000_00F0, 32'd0, 32'h0000_000F);
    checkOutput("ori_alu_ctrl", alu_ctrl, 4'b0001);
    nextEdge();
    checkOutput("ori_out_result", out_result, 32'h0000_00FF);

    applyStimulus(2'b10, 6'b100101, 1'b0, 32'h0000_1200, 32'h0000_0034, 32'd0);
    checkOutput("or_alu_ctrl", alu_ctrl, 4'b0001);
    nextEdge();
    checkOutput("or_out_result", out_result, 32'h0000_1234);

    applyStimulus(2'b10, 6'b000000, 1'b0, 32'd4, 32'd6, 32'd0);
    checkOutput("illegal_alu_ctrl", alu_ctrl, 4'b0010);
    nextEdge();
    checkOutput("illegal_out_illegal", out_illegal, 1);
    checkOutput("illegal_out_result", out_result, 32'd10);
    nextEdge();
    checkOutput("drained_out_valid", out_valid, 0);

    // Fill both stages under backpressure, then reset mid-stall.
    out_ready = 1'b0;
    applyStimulus(2'b00, 6'd0, 1'b0, 32'd1, 32'd2, 32'd0);
    applyStimulus(2'b01, 6'd0, 1'b0, 32'd9, 32'd4, 32'd0);
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_alu_ctrl", alu_ctrl, 4'b0010);
    checkOutput("midrst_op_count", op_count, 0);
    nextEdge();
    checkOutput("midrst_hold_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stream four ops with out_ready low, then drain.
    @(negedge clk);
    setOp(2'b00, 6'd0, 1'b0, 32'd1, 32'd1, 32'd0);
    in_valid = 1'b1;
    #1;
    checkOutput("bp_ready_0", in_ready, 1);
    @(negedge clk);
    setOp(2'b01, 6'd0, 1'b0, 32'd20, 32'd5, 32'd0);
    #1;
    checkOutput("bp_ready_1", in_ready, 1);
    @(negedge clk);
    setOp(2'b11, 6'd0, 1'b0, 32'h30, 32'h3, 32'd0);
    #1;
    checkOutput("bp_ready_stall", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_result0", out_result, 32'd2);
    @(negedge clk);
    #1;
    checkOutput("bp_ready_hold", in_ready, 0);
    checkOutput("bp_result0_hold", out_result, 32'd2);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ready_comb", in_ready, 1);
    @(negedge clk);
    setOp(2'b10, 6'b101010, 1'b0, 32'd9, 32'd2, 32'd0);
    #1;
    checkOutput("bp_result1", out_result, 32'd15);
    checkOutput("bp_valid1", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("bp_result2", out_result, 32'h33);
    @(negedge clk);
    #1;
    checkOutput("bp_result3", out_result, 32'd0);
    checkOutput("bp_zero3", out_zero, 1);
    checkOutput("bp_valid3", out_valid, 1);
    @(negedge clk);
    #1;
    checkOutput("bp_drained", out_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
    checkOutput("bp_op_count", op_count, 32'd4);
`else
    checkOutput("bp_op_count", op_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
